fft_stp_collector: RTL
======================

# fft_stp_collector

Serial-to-parallel frame collector at the input of the FFT core: the mirror of the output parallel-to-serial stage. It shifts in a bit stream MSB-first and assembles NUM_SAMPLES words of DATA_WIDTH bits. It then presents the complete frame to the FFT core in parallel, using a valid/ack handshake. Overrun of the frame buffer is detected and flagged, never silently merged.

## Interface
- DATA_WIDTH, 32, bits per sample word
- NUM_SAMPLES, 16, words per FFT frame (power of two, ≥2)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset: one clock, synchronous, active-high
- serial_in  input  1  serial data bit, sampled when shift_enable=1
- shift_enable  input  1  active-high; accept serial_in this cycle
- frame_sync  input  1  active-high pulse; discard partial frame and restart at word 0, bit 0
- frame_ack  input  1  FFT core consumed the presented frame
- samples  output  NUM_SAMPLES*DATA_WIDTH  frame; word k at [k*DATA_WIDTH +: DATA_WIDTH], word 0 = first received
- frame_valid  output  1  samples holds a complete frame
- overrun  output  1  sticky; a bit was offered with no buffer space
- busy  output  1  partial frame in progress (bit or word counter nonzero)

## Operation
- Counters: bit_cnt 0..DATA_WIDTH-1 and word_cnt 0..NUM_SAMPLES-1; both wrap to 0 at the end of a frame.
- Assembly shift register: shifts left and takes serial_in into the LSB, so the first bit received becomes the word MSB.
- Accepted bit with bit_cnt=DATA_WIDTH-1: the completed word is written to slot word_cnt, then word_cnt increments.
- Completion of word NUM_SAMPLES-1 completes the frame.
- Handshake: frame_valid rises on frame completion and stays high, with samples stable, until a cycle with frame_ack=1. frame_valid is low on the next edge. frame_ack while frame_valid=0 is ignored.
- frame_sync: clears bit_cnt, word_cnt and the partial word. It does not affect frame_valid, samples or overrun.
  - frame_sync and shift_enable in the same cycle: the bit is taken as bit 0 of word 0 of the new frame.
- No space (definition below): shift_enable has no effect on any counter or data, and overrun sets on the next edge. overrun clears only on rst.
- Two states: COLLECT (accepting bits) and FULL (no space). FULL→COLLECT when space frees, as defined per build below.

## Timing
- Reset values: samples=0, frame_valid=0, overrun=0, busy=0, all counters 0.
- Latency: last bit accepted at edge N → frame_valid=1 and samples valid after edge N.
- Throughput: one bit per cycle; a frame takes DATA_WIDTH*NUM_SAMPLES accepted bits (512 at defaults).
- frame_ack and a new frame completing in the same cycle (double-buffer build): the new frame transfers, and frame_valid stays 1 with the new samples.
- rst mid-frame or mid-handshake: everything returns to reset values on that edge. The partial frame and the pending frame are lost.

## Configuration
- FFT_STP_DOUBLE_BUF_EN defined:
  - Separate assembly buffer and output register.
  - Collection continues while frame_valid=1.
  - A completed frame transfers to samples when frame_valid=0 or frame_ack=1 in that cycle.
  - Otherwise the assembly buffer holds the complete frame (state FULL). Further shift_enable is an overrun until the transfer happens.
- Not defined:
  - Single buffer; words are written directly into samples.
  - Any shift_enable while frame_valid=1 is an overrun.
  - A cycle with frame_ack=1 is still no space; collection resumes on the following cycle.

## Structure
- Shared package fft_pkg: FFT_DATA_WIDTH=32, FFT_NUM_SAMPLES=16, and typedef fft_sample_t (logic [31:0]). These are the defaults for both this block and the output stage.
- Sub-module fft_stp_word_sr: DATA_WIDTH shift register plus bit counter, emitting word and word_done. The top level holds the word slots, handshake and overrun logic.

## Test plan
- Reset then 512 bits, word k = 32'hA5000000+k MSB-first, no gaps → frame_valid rises the cycle after bit 511, and word 5 = 32'hA5000005.
- Valid frame, frame_ack held low 100 cycles → samples and frame_valid stable. Ack → frame_valid=0 on the next edge.
- Double-buffer build: second frame streamed while the first is unacked, ack on the exact cycle the second completes → frame_valid stays 1 and samples switch to the second frame, overrun=0.
- Single-buffer build: 1 bit offered while frame_valid=1 → overrun=1 next edge. After ack, the next frame's word 0 is unaffected by that bit.
- 40 bits sent, frame_sync pulsed together with a 1 bit, then 511 further bits → frame completes with word 0 MSB=1 and busy=0 after completion.
- rst asserted at bit 300 → all outputs 0 next edge. A fresh 512-bit frame then completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and types, used by the input collector and the output stage.
package fft_pkg;

  localparam int FFT_DATA_WIDTH  = 32;
  localparam int FFT_NUM_SAMPLES = 16;

  typedef logic [FFT_DATA_WIDTH-1:0] fft_sample_t;

  // COLLECT: bits are accepted. FULL: no buffer space, offered bits are overruns.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } stp_state_t;

endpackage : fft_pkg

// File: rtl/fft_stp_collector_if.sv
// Serial-in / parallel-frame-out bundle between the bit source, the collector and the FFT core.
interface fft_stp_collector_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int NUM_SAMPLES = FFT_NUM_SAMPLES
);

  logic                              serial_in;
  logic                              shift_enable;
  logic                              frame_sync;
  logic                              frame_ack;
  logic [NUM_SAMPLES*DATA_WIDTH-1:0] samples;
  logic                              frame_valid;
  logic                              overrun;
  logic                              busy;

  modport master (
    output serial_in, shift_enable, frame_sync, frame_ack,
    input  samples, frame_valid, overrun, busy
  );

  modport slave (
    input  serial_in, shift_enable, frame_sync, frame_ack,
    output samples, frame_valid, overrun, busy
  );

endinterface : fft_stp_collector_if

// File: rtl/fft_stp_word_sr.sv
// MSB-first word assembler: shift register plus bit counter, flags the cycle a word completes.
module fft_stp_word_sr
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift,
  input  logic                  clear,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done,
  output logic                  pending
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] sr_eff;
  logic [BCW-1:0]        bit_cnt;
  logic [BCW-1:0]        cnt_eff;

  // A clear in the same cycle as a shift makes this bit the first of a fresh word.
  always_comb begin
    sr_eff    = clear ? '0 : sr;
    cnt_eff   = clear ? '0 : bit_cnt;
    word      = {sr_eff[DATA_WIDTH-2:0], serial_in};
    word_done = shift && (cnt_eff == LAST_BIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= word;
      bit_cnt <= word_done ? '0 : cnt_eff + 1'b1;
    end else if (clear) begin
      sr      <= '0;
      bit_cnt <= '0;
    end
  end

  assign pending = (bit_cnt != '0);

endmodule : fft_stp_word_sr

// File: rtl/fft_stp_collector.sv
// Serial-to-parallel FFT frame collector with valid/ack handoff and sticky overrun flag.
// Define FFT_STP_DOUBLE_BUF_EN to keep collecting into a separate assembly buffer while a frame waits.
module fft_stp_collector
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int NUM_SAMPLES = FFT_NUM_SAMPLES
) (
  input logic               clk,
  input logic               rst,
  fft_stp_collector_if.slave bus
);

  localparam int WCW = $clog2(NUM_SAMPLES);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_SAMPLES - 1);

  logic [DATA_WIDTH-1:0] slots [NUM_SAMPLES];
  stp_state_t            state;
  logic                  frame_valid;
  logic                  overrun;
  logic [WCW-1:0]        word_cnt;
  logic [WCW-1:0]        wc_eff;
  logic                  space;
  logic                  accept;
  logic                  word_done;
  logic                  frame_done;
  logic                  bits_pending;
  logic [DATA_WIDTH-1:0] word;

  assign space      = (state == ST_COLLECT);
  assign accept     = bus.shift_enable && space;
  assign wc_eff     = bus.frame_sync ? '0 : word_cnt;
  assign frame_done = word_done && (wc_eff == LAST_WORD);

  fft_stp_word_sr #(.DATA_WIDTH(DATA_WIDTH)) u_word_sr (
    .clk       (clk),
    .rst       (rst),
    .shift     (accept),
    .clear     (bus.frame_sync),
    .serial_in (bus.serial_in),
    .word      (word),
    .word_done (word_done),
    .pending   (bits_pending)
  );

`ifdef FFT_STP_DOUBLE_BUF_EN
  logic [DATA_WIDTH-1:0] asm_buf [NUM_SAMPLES];

  // NOTE: the assembly buffer carries no reset; state and frame_valid say when its contents matter.
  always_ff @(posedge clk) begin
    if (word_done) asm_buf[wc_eff] <= word;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_COLLECT;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      word_cnt    <= '0;
      for (int k = 0; k < NUM_SAMPLES; k++) slots[k] <= '0;
    end else begin
      word_cnt <= word_done ? wc_eff + 1'b1 : wc_eff;
      if (bus.shift_enable && !space) overrun <= 1'b1;
`ifdef FFT_STP_DOUBLE_BUF_EN
      case (state)
        ST_COLLECT: begin
          if (frame_done) begin
            if (!frame_valid || bus.frame_ack) begin
              // Last word bypasses the assembly buffer so the frame lands in one edge.
              for (int k = 0; k < NUM_SAMPLES; k++)
                slots[k] <= (k == NUM_SAMPLES - 1) ? word : asm_buf[k];
              frame_valid <= 1'b1;
            end else begin
              state <= ST_FULL;
            end
          end else if (frame_valid && bus.frame_ack) begin
            frame_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (!frame_valid || bus.frame_ack) begin
            for (int k = 0; k < NUM_SAMPLES; k++) slots[k] <= asm_buf[k];
            frame_valid <= 1'b1;
            state       <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
`else
      if (word_done) slots[wc_eff] <= word;
      if (frame_done) begin
        frame_valid <= 1'b1;
        state       <= ST_FULL;
      end else if (frame_valid && bus.frame_ack) begin
        frame_valid <= 1'b0;
        state       <= ST_COLLECT;
      end
`endif
    end
  end

  for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_flat
    assign bus.samples[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
  end

  assign bus.frame_valid = frame_valid;
  assign bus.overrun     = overrun;
  assign bus.busy        = bits_pending || (word_cnt != '0);

endmodule : fft_stp_collector
